// File: rtl/flippy_pkg.sv
// Shared types, constants and helpers for the falling-letter playfield columns.
package flippy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FALL,
    HIT,
    LANDED
  } col_state_t;

  localparam logic [7:0] LETTER_A = 8'h41;

  // Row period for a difficulty level; the reduction saturates at the floor instead of wrapping.
  function automatic int unsigned period_for_level(
    input int unsigned level,
    input int unsigned base,
    input int unsigned step,
    input int unsigned min_period
  );
    longint unsigned dec;
    dec = 64'(level) * 64'(step);
    if (dec >= 64'(base)) return min_period;
    if ((64'(base) - dec) < 64'(min_period)) return min_period;
    return base - 32'(dec);
  endfunction

  // Off-screen row index used while the column shows no letter.
  function automatic int unsigned hidden_pos(input int unsigned rows);
    return rows + 1;
  endfunction

endpackage

// File: rtl/letter_lfsr.sv
// Free-running 16-bit Galois LFSR with mapping onto a contiguous range of letter codes.
module letter_lfsr
  import flippy_pkg::*;
#(
  parameter logic [15:0]          SEED         = 16'hACE1,
  parameter int unsigned          LETTER_W     = 8,
  parameter logic [LETTER_W-1:0]  LETTER_BASE  = LETTER_W'(LETTER_A),
  parameter int unsigned          LETTER_RANGE = 26
) (
  input  logic                clock,
  input  logic                reset_signal,
  output logic [LETTER_W-1:0] o_candidate
);

  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] r_lfsr;
  logic [15:0] w_offset;

  // Advances every clock so spawn timing never correlates with the letter chosen.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      r_lfsr <= SEED;
    end else if (r_lfsr[0]) begin
      r_lfsr <= (r_lfsr >> 1) ^ TAPS;
    end else begin
      r_lfsr <= r_lfsr >> 1;
    end
  end

  assign w_offset    = r_lfsr % 16'(LETTER_RANGE);
  assign o_candidate = LETTER_BASE + LETTER_W'(w_offset);

endmodule

// File: rtl/letter_column_ctrl.sv
// One playfield column: spawns a random letter, drops it at a level-dependent rate,
// clears it on a matching key and ends the game if it reaches the landing row.
module letter_column_ctrl
  import flippy_pkg::*;
#(
  parameter int unsigned         ROWS         = 22,
  parameter int unsigned         POS_W        = 5,
  parameter int unsigned         LETTER_W     = 8,
  parameter logic [LETTER_W-1:0] LETTER_BASE  = LETTER_W'(LETTER_A),
  parameter int unsigned         LETTER_RANGE = 26,
  parameter int unsigned         BASE_PERIOD  = 50000000,
  parameter int unsigned         PERIOD_STEP  = 4000000,
  parameter int unsigned         MIN_PERIOD   = 5000000,
  parameter int unsigned         LEVEL_W      = 4,
  parameter int unsigned         RESPAWN_GAP  = 25000000,
  parameter logic [15:0]         LFSR_SEED    = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset_signal,
  input  logic                enable,
  input  logic [LEVEL_W-1:0]  speed_level,
  input  logic [LETTER_W-1:0] key_code,
  input  logic                key_valid,
  output logic [POS_W-1:0]    ypos,
  output logic [LETTER_W-1:0] letter,
  output logic                active,
  output logic                hit,
  output logic                game_over
);

  localparam int unsigned CNT_W = $clog2(BASE_PERIOD + 1);
  localparam int unsigned GAP_W = $clog2(RESPAWN_GAP + 1);
  localparam logic [POS_W-1:0] HIDDEN   = POS_W'(hidden_pos(ROWS));
  localparam logic [POS_W-1:0] LAND_ROW = POS_W'(ROWS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESPAWN_GAP - 1);

  col_state_t          r_state;
  logic [CNT_W-1:0]    r_fall_cnt;
  logic [CNT_W-1:0]    r_period;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [POS_W-1:0]    r_ypos;
  logic [LETTER_W-1:0] r_letter;
  logic                r_active;
  logic                r_hit;
  logic                r_game_over;

  logic [LETTER_W-1:0] w_candidate;
  logic [CNT_W-1:0]    w_period;
  logic [POS_W-1:0]    w_ypos_next;
  logic                w_key_match;

  letter_lfsr #(
    .SEED         (LFSR_SEED),
    .LETTER_W     (LETTER_W),
    .LETTER_BASE  (LETTER_BASE),
    .LETTER_RANGE (LETTER_RANGE)
  ) u_lfsr (
    .clock        (clock),
    .reset_signal (reset_signal),
    .o_candidate  (w_candidate)
  );

  assign w_period    = CNT_W'(period_for_level(32'(speed_level), BASE_PERIOD,
                                               PERIOD_STEP, MIN_PERIOD));
  assign w_ypos_next = r_ypos + POS_W'(1);
  assign w_key_match = key_valid && (key_code == r_letter);

  // Column FSM; the period is latched at each reload so level changes land on row boundaries.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      r_state     <= IDLE;
      r_fall_cnt  <= '0;
      r_period    <= '0;
      r_gap_cnt   <= '0;
      r_ypos      <= HIDDEN;
      r_letter    <= '0;
      r_active    <= 1'b0;
      r_hit       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ypos <= HIDDEN;
          if (enable) r_state <= SPAWN;
        end
        SPAWN: begin
          r_letter   <= w_candidate;
          r_ypos     <= '0;
          r_active   <= 1'b1;
          r_fall_cnt <= '0;
          r_period   <= w_period;
          r_state    <= FALL;
        end
        FALL: begin
          // A matching key beats a simultaneous landing tick.
          if (w_key_match) begin
            r_hit      <= 1'b1;
            r_active   <= 1'b0;
            r_ypos     <= HIDDEN;
            r_fall_cnt <= '0;
            r_gap_cnt  <= '0;
            r_state    <= HIT;
          end else if (enable) begin
            if (r_fall_cnt == r_period - CNT_W'(1)) begin
              r_fall_cnt <= '0;
              r_period   <= w_period;
              r_ypos     <= w_ypos_next;
              if (w_ypos_next == LAND_ROW) begin
                r_game_over <= 1'b1;
                r_active    <= 1'b0;
                r_state     <= LANDED;
              end
            end else begin
              r_fall_cnt <= r_fall_cnt + CNT_W'(1);
            end
          end
        end
        HIT: begin
          if (enable) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt <= '0;
              r_state   <= SPAWN;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
        end
        LANDED: begin
          r_active    <= 1'b0;
          r_game_over <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ypos      = r_ypos;
  assign letter    = r_letter;
  assign active    = r_active;
  assign hit       = r_hit;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_letter_column_ctrl.sv
// Directed bench for letter_column_ctrl with a small, fast column configuration.
module tb_letter_column_ctrl;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned POS_W    = 3;
  localparam int unsigned LETTER_W = 8;
  localparam int unsigned LEVEL_W  = 4;
  localparam logic [POS_W-1:0] HID = 3'd5;

  logic                clock;
  logic                reset_signal;
  logic                enable;
  logic [LEVEL_W-1:0]  speed_level;
  logic [LETTER_W-1:0] key_code;
  logic                key_valid;
  logic [POS_W-1:0]    ypos;
  logic [LETTER_W-1:0] letter;
  logic                active;
  logic                hit;
  logic                game_over;

  int n_checks;
  int n_errors;
  logic [LETTER_W-1:0] lt;

  letter_column_ctrl #(
    .ROWS         (ROWS),
    .POS_W        (POS_W),
    .LETTER_W     (LETTER_W),
    .LETTER_BASE  (8'h41),
    .LETTER_RANGE (26),
    .BASE_PERIOD  (10),
    .PERIOD_STEP  (2),
    .MIN_PERIOD   (4),
    .LEVEL_W      (LEVEL_W),
    .RESPAWN_GAP  (3),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clock        (clock),
    .reset_signal (reset_signal),
    .enable       (enable),
    .speed_level  (speed_level),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .ypos         (ypos),
    .letter       (letter),
    .active       (active),
    .hit          (hit),
    .game_over    (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_signal = 1'b1;
    enable       = 1'b0;
    key_valid    = 1'b0;
    key_code     = '0;
    tick(2);
    reset_signal = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset_signal = 1'b1;
    enable       = 1'b0;
    speed_level  = '0;
    key_code     = '0;
    key_valid    = 1'b0;
    #3;
    check("rst_ypos", 32'(ypos), 32'(HID));
    check("rst_letter", 32'(letter), 0);
    check("rst_active", 32'(active), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_game_over", 32'(game_over), 0);

    // Free fall to the landing row at level 0.
    do_reset();
    enable = 1'b1;
    tick(1);
    check("idle_to_spawn_ypos", 32'(ypos), 32'(HID));
    tick(1);
    check("spawn_ypos", 32'(ypos), 0);
    check("spawn_active", 32'(active), 1);
    check("spawn_letter_range", 32'(letter >= 8'h41 && letter <= 8'h5A), 1);
    tick(9);
    check("row0_hold", 32'(ypos), 0);
    tick(1);
    check("row1", 32'(ypos), 1);
    tick(10);
    check("row2", 32'(ypos), 2);
    tick(10);
    check("row3", 32'(ypos), 3);
    check("pre_land_game_over", 32'(game_over), 0);
    tick(10);
    check("land_ypos", 32'(ypos), 4);
    check("land_game_over", 32'(game_over), 1);
    check("land_active", 32'(active), 0);
    lt = letter;
    for (int i = 0; i < 100; i++) begin
      key_valid = 1'(i % 2);
      key_code  = lt;
      tick(1);
      check("landed_game_over", 32'(game_over), 1);
      check("landed_hit", 32'(hit), 0);
    end
    key_valid = 1'b0;
    check("landed_ypos", 32'(ypos), 4);
    check("landed_letter_held", 32'(letter), 32'(lt));

    // Correct key at row 2, respawn after the gap, then a wrong key.
    do_reset();
    enable = 1'b1;
    tick(2);
    check("spawn2_ypos", 32'(ypos), 0);
    tick(20);
    check("hit_row2", 32'(ypos), 2);
    tick(3);
    lt        = letter;
    key_code  = lt;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    check("hit_pulse", 32'(hit), 1);
    check("hit_ypos", 32'(ypos), 32'(HID));
    check("hit_active", 32'(active), 0);
    check("hit_letter_held", 32'(letter), 32'(lt));
    tick(1);
    check("hit_one_cycle", 32'(hit), 0);
    tick(2);
    check("gap_hidden", 32'(ypos), 32'(HID));
    tick(1);
    check("respawn_ypos", 32'(ypos), 0);
    check("respawn_active", 32'(active), 1);
    check("respawn_letter_range", 32'(letter >= 8'h41 && letter <= 8'h5A), 1);
    tick(4);
    key_code  = letter ^ 8'h20;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    check("wrong_key_no_hit", 32'(hit), 0);
    check("wrong_key_ypos", 32'(ypos), 0);
    tick(4);
    check("wrong_key_row0_hold", 32'(ypos), 0);
    tick(1);
    check("wrong_key_row1", 32'(ypos), 1);

    // Level 2 gives 6-cycle rows; level 15 saturates to 4 from the next row.
    do_reset();
    speed_level = 4'd2;
    enable      = 1'b1;
    tick(2);
    check("lvl2_spawn", 32'(ypos), 0);
    tick(5);
    check("lvl2_row0_hold", 32'(ypos), 0);
    tick(1);
    check("lvl2_row1", 32'(ypos), 1);
    tick(3);
    speed_level = 4'd15;
    tick(2);
    check("lvl_change_row1_hold", 32'(ypos), 1);
    tick(1);
    check("lvl_change_row2", 32'(ypos), 2);
    tick(3);
    check("lvl15_row2_hold", 32'(ypos), 2);
    tick(1);
    check("lvl15_row3", 32'(ypos), 3);

    // Correct key on the same edge as the landing tick.
    tick(3);
    lt        = letter;
    key_code  = lt;
    key_valid = 1'b1;
    tick(1);
    key_valid   = 1'b0;
    speed_level = '0;
    check("race_hit", 32'(hit), 1);
    check("race_game_over", 32'(game_over), 0);
    check("race_ypos", 32'(ypos), 32'(HID));
    tick(3);
    check("race_gap_hidden", 32'(ypos), 32'(HID));
    check("race_game_over_gap", 32'(game_over), 0);
    tick(1);
    check("race_respawn", 32'(ypos), 0);

    // Pause for 20 cycles mid-row; the residual count resumes afterwards.
    tick(4);
    enable = 1'b0;
    tick(20);
    check("pause_ypos", 32'(ypos), 0);
    check("pause_active", 32'(active), 1);
    enable = 1'b1;
    tick(5);
    check("resume_row0_hold", 32'(ypos), 0);
    tick(1);
    check("resume_row1", 32'(ypos), 1);

    // A correct key while paused still hits; the gap waits for enable.
    enable    = 1'b0;
    key_code  = letter;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    check("paused_hit", 32'(hit), 1);
    check("paused_hit_ypos", 32'(ypos), 32'(HID));
    tick(5);
    check("paused_gap_hidden", 32'(ypos), 32'(HID));
    check("paused_gap_active", 32'(active), 0);
    enable = 1'b1;
    tick(1);

    // Asynchronous reset in the middle of the gap.
    reset_signal = 1'b1;
    #2;
    check("async_rst_ypos", 32'(ypos), 32'(HID));
    check("async_rst_letter", 32'(letter), 0);
    check("async_rst_active", 32'(active), 0);
    check("async_rst_hit", 32'(hit), 0);
    check("async_rst_game_over", 32'(game_over), 0);
    tick(2);
    reset_signal = 1'b0;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/letter_column_ctrl.md
Name: letter_column_ctrl

Overview:
- Parametrised next-generation falling-letter column for the typing game.
- A pseudo-random letter spawns at the top of the column and falls one row per period; the fall speeds up with the level.
- Correct key strobes clear the letter and trigger a respawn.
- One instance per playfield column. The game top ORs game_over across columns and counts hit pulses for the score.

Parameters:
- ROWS, 22, landing row index; reaching it ends the game for this column.
- POS_W, 5, width of ypos; must hold ROWS+1.
- LETTER_W, 8, letter/key code width.
- LETTER_BASE, 8'h41, lowest spawned code ('A').
- LETTER_RANGE, 26, number of distinct spawned codes.
- BASE_PERIOD, 50000000, clocks per row at level 0.
- PERIOD_STEP, 4000000, period reduction per level.
- MIN_PERIOD, 5000000, floor on the fall period.
- LEVEL_W, 4, speed_level width.
- RESPAWN_GAP, 25000000, clocks the column stays empty after a hit.
- LFSR_SEED, 16'hACE1, nonzero seed; differs per column instance.

Ports:
- clock, input, 1, system clock.
- reset_signal, input, 1, asynchronous, active-high reset.
- enable, input, 1, run/pause; low freezes fall and gap counters.
- speed_level, input, LEVEL_W, current difficulty level.
- key_code, input, LETTER_W, decoded keyboard code.
- key_valid, input, 1, one-cycle strobe qualifying key_code.
- ypos, output, POS_W, current row; HIDDEN = ROWS+1 when no letter is shown.
- letter, output, LETTER_W, letter currently displayed.
- active, output, 1, high while a letter is falling.
- hit, output, 1, one-cycle pulse on a correct key.
- game_over, output, 1, held high once the letter lands, until reset.

Behaviour:
- Reset (async, immediate) values:
  - ypos=HIDDEN, letter=0, active=0, hit=0, game_over=0.
  - state=IDLE, fall_cnt=0, gap_cnt=0, lfsr=LFSR_SEED.
- LFSR: 16-bit maximal Galois LFSR, advances every clock regardless of state or enable.
- Candidate letter = LETTER_BASE + (lfsr mod LETTER_RANGE).
- Period = max(BASE_PERIOD - speed_level*PERIOD_STEP, MIN_PERIOD).
  - Computed with no underflow; the subtraction saturates to MIN_PERIOD.
  - Sampled on every counter reload, so a level change takes effect on the next row.
- All outputs are registered; no combinational path from key inputs to outputs.
- States:
  - IDLE: ypos=HIDDEN. enable=1 -> SPAWN.
  - SPAWN (1 cycle): letter<=candidate, ypos<=0, active<=1, fall_cnt<=0 -> FALL.
  - FALL:
    - If enable, fall_cnt increments. At fall_cnt==period-1: fall_cnt<=0, ypos<=ypos+1.
    - If the new ypos==ROWS -> LANDED, with game_over<=1 in the same edge.
    - key_valid && key_code==letter -> HIT: hit<=1 for one cycle, active<=0, ypos<=HIDDEN.
    - key_valid with a wrong code is ignored; no penalty.
  - HIT: gap_cnt counts RESPAWN_GAP cycles (paused while enable=0), then -> SPAWN.
  - LANDED: active=0; ypos stays ROWS; game_over stays 1. Terminal until reset; keys ignored.
- First row step occurs exactly period cycles after SPAWN.
- Simultaneous correct key and landing tick in the same cycle: the hit wins; game_over stays 0.
- key_valid during SPAWN, HIT or IDLE is ignored.
- enable deasserted mid-fall: counters and ypos hold. A correct key still registers a hit.
- Reset mid-fall or mid-gap returns to IDLE immediately. The LFSR reloads the seed, giving deterministic restart.
- The letter holds its value through HIT and LANDED; it changes only in SPAWN.

Decomposition:
- Shared package flippy_pkg holds:
  - column state enum (IDLE, SPAWN, FALL, HIT, LANDED);
  - ASCII constants (LETTER_A=8'h41);
  - function period_for_level(level, base, step, min);
  - HIDDEN position helper.
- One sub-module, letter_lfsr: seed parameter, free-running 16-bit LFSR plus mod-range letter mapping.
- State machine and counters live in letter_column_ctrl.

Test Plan (ROWS=4, BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=4, RESPAWN_GAP=3, level 0 unless stated):
- Reset then enable=1 -> SPAWN next cycle; ypos=0, active=1; ypos steps 1,2,3,4 at 10-cycle intervals. At ypos=4, game_over=1 and stays 1 for 100 further cycles with keys applied.
- Strobe key_valid with key_code==letter at ypos=2 -> hit high for exactly 1 cycle, ypos=HIDDEN. After 3 gap cycles, SPAWN with ypos=0 and a letter within 8'h41..8'h5A.
- Wrong key_code strobe during FALL -> no hit, ypos cadence unchanged.
- speed_level=2 -> 6-cycle rows; speed_level=15 -> saturates to 4-cycle rows; a level change mid-row applies from the next row.
- Correct key on the same cycle the landing tick fires at ypos 3->4 -> hit=1, game_over=0, state HIT.
- enable=0 for 20 cycles mid-fall -> ypos frozen, row timing resumes with the residual count. Assert reset_signal asynchronously mid-gap -> all outputs return to reset values before the next clock edge.
